// File: rtl/capture_pkg.sv
// Shared constants and types for the DPI output capture stage.
package capture_pkg;

  localparam int DROP_CNT_W    = 16;
  localparam int CAPTURE_WIDTH = 32;
  localparam int CAPTURE_DEPTH = 8;

  typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

endpackage

// File: rtl/capture_fifo.sv
// Synchronous first-word-fall-through FIFO; occupancy tracked by an explicit level count.
module capture_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic [LW-1:0]    level_next;

  // Caller guarantees push only when not full (or popping) and pop only when non-empty.
  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg <= level_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr_reg] <= wr_data;
  end

  // Head is forced to zero while empty so reset and flush present a clean bus.
  assign rd_valid = (level_reg != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr_reg] : '0;
  assign level    = level_reg;

endmodule

// File: rtl/dpi_out_capture.sv
// Capture stage for the DPI model output: change filter, drop accounting and a FWFT buffer.
module dpi_out_capture
  import capture_pkg::*;
#(
  parameter int WIDTH       = CAPTURE_WIDTH,
  parameter int DEPTH       = CAPTURE_DEPTH,
  parameter bit CHANGE_ONLY = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output drop_cnt_t              drop_cnt
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] last_val_reg;
  logic             last_vld_reg;
  logic             overflow_reg;
  drop_cnt_t        drop_cnt_reg;

  logic accept;
  logic pop;
  logic full;
  logic push;
  logic drop;

  assign accept = in_valid && (!CHANGE_ONLY || !last_vld_reg || (in_data != last_val_reg));
  assign pop    = out_valid && out_ready;
  assign full   = (level == LW'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still takes the new sample.
  assign push   = accept && (!full || pop);
  assign drop   = accept && full && !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_val_reg <= '0;
      last_vld_reg <= 1'b0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else if (clear) begin
      last_vld_reg <= 1'b0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      // History follows every accepted sample, even one that is then dropped.
      if (accept) begin
        last_val_reg <= in_data;
        last_vld_reg <= 1'b1;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != '1) drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
    end
  end

  capture_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .clear    (clear),
    .push     (push),
    .pop      (pop),
    .wr_data  (in_data),
    .rd_data  (out_data),
    .rd_valid (out_valid),
    .level    (level)
  );

  assign overflow = overflow_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_dpi_out_capture.sv
// Directed bench for dpi_out_capture: queue-based model for the filtered instance plus literal checks.
module tb_dpi_out_capture;

  localparam int W = 32;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;

  logic [W-1:0] f_data, n_data;
  logic         f_valid, n_valid;
  logic [3:0]   f_level, n_level;
  logic         f_ovf, n_ovf;
  logic [15:0]  f_dcnt, n_dcnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dpi_out_capture #(.WIDTH(W), .DEPTH(D), .CHANGE_ONLY(1'b1)) dut_f (
    .clk(clk), .reset(reset), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .out_data(f_data), .out_valid(f_valid), .out_ready(out_ready),
    .level(f_level), .overflow(f_ovf), .drop_cnt(f_dcnt)
  );

  dpi_out_capture #(.WIDTH(W), .DEPTH(D), .CHANGE_ONLY(1'b0)) dut_n (
    .clk(clk), .reset(reset), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .out_data(n_data), .out_valid(n_valid), .out_ready(out_ready),
    .level(n_level), .overflow(n_ovf), .drop_cnt(n_dcnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the filtered instance: a plain queue of accepted samples.
  logic [31:0] m_q[$];
  logic [31:0] m_last_val = '0;
  bit          m_last_vld = 1'b0;
  bit          m_ovf = 1'b0;
  int          m_dcnt = 0;

  always @(posedge clk or negedge reset) begin : m_step
    bit do_pop, was_full, acc;
    if (!reset) begin
      m_q.delete();
      m_last_val = '0;
      m_last_vld = 1'b0;
      m_ovf = 1'b0;
      m_dcnt = 0;
    end else if (clear) begin
      m_q.delete();
      m_last_vld = 1'b0;
      m_ovf = 1'b0;
      m_dcnt = 0;
    end else begin
      do_pop   = (m_q.size() != 0) && out_ready;
      was_full = (m_q.size() == D);
      acc      = in_valid && (!m_last_vld || in_data != m_last_val);
      if (acc) begin
        m_last_val = in_data;
        m_last_vld = 1'b1;
      end
      if (do_pop) void'(m_q.pop_front());
      if (acc) begin
        if (!was_full || do_pop) m_q.push_back(in_data);
        else begin
          if (m_dcnt < 65535) m_dcnt++;
          m_ovf = 1'b1;
        end
      end
    end
  end

  logic [31:0] pop_f[$];
  logic [31:0] pop_n[$];

  // Compare on the falling edge, and record which heads will be consumed at the next rising edge.
  always @(negedge clk) begin
    chk("model_out_valid", {31'b0, f_valid}, {31'b0, m_q.size() != 0});
    chk("model_level", {28'b0, f_level}, m_q.size());
    if (m_q.size() != 0) chk("model_out_data", f_data, m_q[0]);
    chk("model_overflow", {31'b0, f_ovf}, {31'b0, m_ovf});
    chk("model_drop_cnt", {16'b0, f_dcnt}, m_dcnt);
    if (f_valid && out_ready) pop_f.push_back(f_data);
    if (n_valid && out_ready) pop_n.push_back(n_data);
  end

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  task automatic chk_seq(input string name);
    chk({name, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk(name, got_q[i], exp_q[i]);
  endtask

  task automatic cyc(input logic v, input logic [31:0] d, input logic r, input logic c);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clear     = c;
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", {31'b0, f_valid}, 32'd0);
    chk("rst_out_data", f_data, 32'd0);
    chk("rst_level", {28'b0, f_level}, 32'd0);
    chk("rst_overflow", {31'b0, f_ovf}, 32'd0);
    chk("rst_drop_cnt", {16'b0, f_dcnt}, 32'd0);
    reset = 1'b1;

    // Change filter vs. no filter on the same stream.
    pop_f.delete(); pop_n.delete();
    exp_q = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd2};
    for (int i = 0; i < 6; i++) cyc(1'b1, exp_q[i], 1'b1, 1'b0);
    drain(3);
    got_q = pop_n; chk_seq("nofilter_seq");
    got_q = pop_f; exp_q = '{32'd0, 32'd1, 32'd2}; chk_seq("filter_seq");
    chk("filter_drop_cnt", {16'b0, f_dcnt}, 32'd0);

    // Overflow: ten distinct samples into eight slots with no consumer.
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) cyc(1'b1, i, 1'b0, 1'b0);
    chk("ovf_level", {28'b0, f_level}, 32'd8);
    chk("ovf_drop_cnt", {16'b0, f_dcnt}, 32'd2);
    chk("ovf_flag", {31'b0, f_ovf}, 32'd1);
    chk("ovf_nf_drop_cnt", {16'b0, n_dcnt}, 32'd2);
    pop_f.delete(); pop_n.delete();
    drain(10);
    exp_q.delete();
    for (int i = 1; i <= 8; i++) exp_q.push_back(i);
    got_q = pop_f; chk_seq("ovf_drain");
    got_q = pop_n; chk_seq("ovf_nf_drain");

    // Full with a simultaneous push and pop.
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) cyc(1'b1, i, 1'b0, 1'b0);
    pop_f.delete();
    cyc(1'b1, 32'd9, 1'b1, 1'b0);
    chk("fullpp_level", {28'b0, f_level}, 32'd8);
    chk("fullpp_drop_cnt", {16'b0, f_dcnt}, 32'd0);
    got_q = pop_f; exp_q = '{32'd1}; chk_seq("fullpp_first");
    drain(10);
    exp_q.delete();
    for (int i = 1; i <= 9; i++) exp_q.push_back(i);
    got_q = pop_f; chk_seq("fullpp_drain");

    // Clear beats a simultaneous push, and forgets the change history.
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) cyc(1'b1, i, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("pre_clear_level", {28'b0, f_level}, 32'd5);
    chk("pre_clear_ovf", {31'b0, f_ovf}, 32'd1);
    cyc(1'b1, 32'd11, 1'b0, 1'b1);
    chk("clear_level", {28'b0, f_level}, 32'd0);
    chk("clear_out_valid", {31'b0, f_valid}, 32'd0);
    chk("clear_drop_cnt", {16'b0, f_dcnt}, 32'd0);
    chk("clear_ovf", {31'b0, f_ovf}, 32'd0);
    cyc(1'b1, 32'd10, 1'b0, 1'b0);
    chk("post_clear_level", {28'b0, f_level}, 32'd1);
    chk("post_clear_data", f_data, 32'd10);

    // Asynchronous reset between edges while three entries are buffered.
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) cyc(1'b1, i, 1'b0, 1'b0);
    chk("pre_rst_level", {28'b0, f_level}, 32'd3);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'b0, f_valid}, 32'd0);
    chk("async_rst_level", {28'b0, f_level}, 32'd0);
    chk("async_rst_out_data", f_data, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    cyc(1'b1, 32'd3, 1'b0, 1'b0);
    chk("post_rst_level", {28'b0, f_level}, 32'd1);
    chk("post_rst_data", f_data, 32'd3);
    drain(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dpi_out_capture.md
# dpi_out_capture

Downstream capture stage for the Python-DPI generated model output. Samples the model's `out` bus each cycle it is qualified and optionally discards repeats of the previous accepted value. Accepted samples are buffered in a small FIFO and presented to a checker or logger over a valid/ready interface. Overflow drops are counted rather than back-pressuring the model, because the DPI model cannot stall.

## Interface

Parameters:
- WIDTH, 32, bit width of the captured `out` value
- DEPTH, 8, FIFO entries; power of two, minimum 2
- CHANGE_ONLY, 1, 1 = push only when the sample differs from the last accepted sample; 0 = push every valid sample

Ports:
- clk  input  1  single clock, all logic on posedge
- reset  input  1  asynchronous, active-low reset
- clear  input  1  synchronous flush of FIFO, counters and change history
- in_data  input  WIDTH  model `out` value
- in_valid  input  1  in_data is sampled this cycle
- out_data  output  WIDTH  head-of-FIFO value
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts head when out_valid is high
- level  output  $clog2(DEPTH)+1  current occupancy
- overflow  output  1  sticky: at least one sample was dropped
- drop_cnt  output  16  number of dropped samples, saturating at 16'hFFFF

## Operation

- Accept: the sample is `in_valid && (!CHANGE_ONLY || !last_vld || in_data != last_val)`.
- On accept, `last_val <= in_data` and `last_vld <= 1`. The change history updates even if the push is then dropped.
- Pop: `out_valid && out_ready`.
- Push: accept and (not full, or pop in the same cycle). With full and a simultaneous pop, the push succeeds and level is unchanged.
- Drop: accept, full, and no pop. On drop:
  - `drop_cnt` increments, saturating.
  - `overflow` sets.
  - FIFO contents are unchanged (newest sample is lost).
- Empty with simultaneous push and no pop: level goes 0 -> 1. No bypass; the data appears on the next cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty is derived from `level`.
- `clear` has priority over push, pop and drop in the same cycle:
  - level, pointers, drop_cnt, overflow and last_vld go to 0.
  - FIFO RAM contents are don't-care.

## Timing

- Reset values: out_valid=0, out_data=0, level=0, overflow=0, drop_cnt=0, last_vld=0, last_val=0.
- Reset assertion takes effect immediately and asynchronously. Deassertion is sampled on the next posedge. A reset in the middle of traffic loses all buffered data.
- Latency: a sample pushed at edge N appears on out_data/out_valid after edge N (registered head, FWFT). It is visible in cycle N+1.
- out_data holds stable while out_valid=1 and out_ready=0.
- out_data is don't-care when out_valid=0.
- level, overflow and drop_cnt are registered and update at the same edge as the push/pop/drop that changes them.
- Throughput: one push and one pop per cycle, sustained.

## Structure

- Package `capture_pkg`:
  - `DROP_CNT_W = 16`.
  - Default `CAPTURE_WIDTH` / `CAPTURE_DEPTH`.
  - `typedef logic [DROP_CNT_W-1:0] drop_cnt_t`.
- Sub-module `capture_fifo`:
  - Generic synchronous FWFT FIFO with WIDTH, DEPTH, push, pop, clear and level.
  - Same clk / active-low async reset.
- `dpi_out_capture` contains:
  - The change detector (last_val/last_vld).
  - Drop accounting.
  - One `capture_fifo` instance.

## Test plan

- **Change filter.** Reset, CHANGE_ONLY=1, in_valid=1 with in_data sequence 0,0,1,1,1,2; out_ready=1. Required: out_data delivers exactly 0,1,2; drop_cnt=0.
- **No filter.** CHANGE_ONLY=0, same stimulus. Required: 6 entries popped, in order 0,0,1,1,1,2.
- **Overflow.** DEPTH=8, out_ready=0, 10 distinct samples 1..10. Required: level=8, drop_cnt=2, overflow=1. Then out_ready=1 pops 1..8 only.
- **Full with simultaneous push/pop.** FIFO full (1..8), then push 9 with out_ready=1. Required: 1 popped, level stays 8, drop_cnt unchanged, final drain 2..9.
- **Clear priority.** Level=5, overflow=1, assert clear together with a valid push. Required next cycle: level=0, out_valid=0, drop_cnt=0, overflow=0. The next sample equal to the old last_val is accepted because last_vld was cleared.
- **Async reset mid-stream.** Pull reset low between clock edges while level=3. Required: out_valid=0 and level=0 immediately, before the next posedge. After release, the first sample is pushed regardless of value.
